// File: rtl/shift_div_if.sv
// Start/busy handshake bundle for the shift-subtract divider: operands and start in,
// quotient/remainder with busy/done/div_zero status out.
interface shift_div_if #(
  parameter int DIVIDEND_WIDTH = 16,
  parameter int DIVISOR_WIDTH  = 8
);
  logic [DIVIDEND_WIDTH-1:0] dividend;
  logic [DIVISOR_WIDTH-1:0]  divisor;
  logic                      start;
  logic [DIVIDEND_WIDTH-1:0] quotient;
  logic [DIVISOR_WIDTH-1:0]  remainder;
  logic                      busy;
  logic                      done;
  logic                      div_zero;

  modport master (
    output dividend, divisor, start,
    input  quotient, remainder, busy, done, div_zero
  );

  modport slave (
    input  dividend, divisor, start,
    output quotient, remainder, busy, done, div_zero
  );
endinterface

// File: rtl/shift_div.sv
// Sequential restoring unsigned divider producing one quotient bit per clock,
// with a one-cycle shortcut for divide-by-zero.
module shift_div #(
  parameter int DIVIDEND_WIDTH = 16,
  parameter int DIVISOR_WIDTH  = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  shift_div_if.slave bus
);
  localparam int W  = DIVIDEND_WIDTH;
  localparam int D  = DIVISOR_WIDTH;
  localparam int CW = $clog2(W + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] ZERO = 2'd2;

  logic [1:0]    state;
  logic [W-1:0]  dvd_reg;
  logic [D-1:0]  dvs_reg;
  logic [D-1:0]  pr;
  logic [CW-1:0] cnt;

  logic [D:0]    pr_shift;
  logic [D-1:0]  pr_next;
  logic          q_bit;

  // The stored partial remainder is always below the divisor, so only the trial
  // value after shifting needs the extra (D+1-th) bit for the compare.
  always_comb begin
    pr_shift = {pr, dvd_reg[W-1]};
    q_bit    = (pr_shift >= {1'b0, dvs_reg});
    pr_next  = pr_shift[D-1:0];
    if (q_bit) begin
      pr_next = D'(pr_shift - {1'b0, dvs_reg});
    end
  end

  assign bus.busy = (state != IDLE);

  // Quotient bits shift into the vacated low end of the dividend register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      dvd_reg       <= '0;
      dvs_reg       <= '0;
      pr            <= '0;
      cnt           <= '0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.done      <= 1'b0;
      bus.div_zero  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            dvd_reg <= bus.dividend;
            dvs_reg <= bus.divisor;
            pr      <= '0;
            cnt     <= CW'(W);
            state   <= (bus.divisor == '0) ? ZERO : RUN;
          end
        end
        RUN: begin
          pr      <= pr_next;
          dvd_reg <= {dvd_reg[W-2:0], q_bit};
          cnt     <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            bus.quotient  <= {dvd_reg[W-2:0], q_bit};
            bus.remainder <= pr_next;
            bus.div_zero  <= 1'b0;
            bus.done      <= 1'b1;
            state         <= IDLE;
          end
        end
        ZERO: begin
          bus.quotient  <= '1;
          bus.remainder <= '0;
          bus.div_zero  <= 1'b1;
          bus.done      <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_div.sv
// Directed self-checking bench for shift_div: normal division, limits, divide-by-zero,
// ignored start while busy, mid-operation reset and back-to-back operation.
module tb_shift_div;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  shift_div_if #(.DIVIDEND_WIDTH(16), .DIVISOR_WIDTH(8)) bus ();

  shift_div #(.DIVIDEND_WIDTH(16), .DIVISOR_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drives operands with start for one accepting edge; returns 1 time unit after it.
  task automatic start_op(input logic [15:0] a, input logic [7:0] b);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
  endtask

  // Counts edges until done is seen; -1 if it never arrives within the budget.
  task automatic wait_done(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        cycles = i;
        return;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.quotient !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_quotient: got %0d expected 0", bus.quotient); end
    n_checks++; if (bus.remainder !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_remainder: got %0d expected 0", bus.remainder); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
    n_checks++; if (bus.div_zero !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_div_zero: got %b expected 0", bus.div_zero); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int cyc;
    start_op(16'd1000, 8'd7);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_busy: got %b expected 1", bus.busy); end
    wait_done(cyc);
    n_checks++; if (cyc !== 16) begin n_fail++; $display("[TB] FAIL basic_latency: got %0d expected 16", cyc); end
    n_checks++; if (bus.quotient !== 16'd142) begin n_fail++; $display("[TB] FAIL basic_quotient: got %0d expected 142", bus.quotient); end
    n_checks++; if (bus.remainder !== 8'd6) begin n_fail++; $display("[TB] FAIL basic_remainder: got %0d expected 6", bus.remainder); end
    n_checks++; if (bus.div_zero !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_div_zero: got %b expected 0", bus.div_zero); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_busy_at_done: got %b expected 0", bus.busy); end
    @(posedge clk); #1;
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_done_pulse: got %b expected 0", bus.done); end
    n_checks++; if (bus.quotient !== 16'd142) begin n_fail++; $display("[TB] FAIL basic_hold: got %0d expected 142", bus.quotient); end
  endtask

  task automatic test_limits;
    int cyc;
    start_op(16'd65535, 8'd255);
    wait_done(cyc);
    n_checks++; if (cyc !== 16) begin n_fail++; $display("[TB] FAIL lim255_latency: got %0d expected 16", cyc); end
    n_checks++; if (bus.quotient !== 16'd257) begin n_fail++; $display("[TB] FAIL lim255_quotient: got %0d expected 257", bus.quotient); end
    n_checks++; if (bus.remainder !== 8'd0) begin n_fail++; $display("[TB] FAIL lim255_remainder: got %0d expected 0", bus.remainder); end
    @(posedge clk); #1;
    start_op(16'd65535, 8'd1);
    wait_done(cyc);
    n_checks++; if (cyc !== 16) begin n_fail++; $display("[TB] FAIL lim1_latency: got %0d expected 16", cyc); end
    n_checks++; if (bus.quotient !== 16'hFFFF) begin n_fail++; $display("[TB] FAIL lim1_quotient: got %h expected ffff", bus.quotient); end
    n_checks++; if (bus.remainder !== 8'd0) begin n_fail++; $display("[TB] FAIL lim1_remainder: got %0d expected 0", bus.remainder); end
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero;
    int cyc;
    start_op(16'd5, 8'd0);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL zero_busy: got %b expected 1", bus.busy); end
    wait_done(cyc);
    n_checks++; if (cyc !== 1) begin n_fail++; $display("[TB] FAIL zero_latency: got %0d expected 1", cyc); end
    n_checks++; if (bus.quotient !== 16'hFFFF) begin n_fail++; $display("[TB] FAIL zero_quotient: got %h expected ffff", bus.quotient); end
    n_checks++; if (bus.remainder !== 8'd0) begin n_fail++; $display("[TB] FAIL zero_remainder: got %0d expected 0", bus.remainder); end
    n_checks++; if (bus.div_zero !== 1'b1) begin n_fail++; $display("[TB] FAIL zero_flag: got %b expected 1", bus.div_zero); end
    @(posedge clk); #1;
    start_op(16'd100, 8'd10);
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (bus.div_zero !== 1'b1) begin n_fail++; $display("[TB] FAIL zero_flag_hold: got %b expected 1", bus.div_zero); end
    wait_done(cyc);
    n_checks++; if (cyc !== 11) begin n_fail++; $display("[TB] FAIL zero_next_latency: got %0d expected 11", cyc); end
    n_checks++; if (bus.quotient !== 16'd10) begin n_fail++; $display("[TB] FAIL zero_next_quotient: got %0d expected 10", bus.quotient); end
    n_checks++; if (bus.remainder !== 8'd0) begin n_fail++; $display("[TB] FAIL zero_next_remainder: got %0d expected 0", bus.remainder); end
    n_checks++; if (bus.div_zero !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_flag_clear: got %b expected 0", bus.div_zero); end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start;
    int done_cnt;
    int done_edge;
    done_cnt = 0; done_edge = -1;
    start_op(16'd3, 8'd200);
    for (int i = 1; i <= 25; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin done_cnt++; if (done_edge < 0) done_edge = i; end
      bus.start = 1'b0;
      if (i == 4) begin
        bus.dividend = 16'd50000; bus.divisor = 8'd3; bus.start = 1'b1;
      end
    end
    n_checks++; if (done_edge !== 16) begin n_fail++; $display("[TB] FAIL ignore_latency: got %0d expected 16", done_edge); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("[TB] FAIL ignore_done_count: got %0d expected 1", done_cnt); end
    n_checks++; if (bus.quotient !== 16'd0) begin n_fail++; $display("[TB] FAIL ignore_quotient: got %0d expected 0", bus.quotient); end
    n_checks++; if (bus.remainder !== 8'd3) begin n_fail++; $display("[TB] FAIL ignore_remainder: got %0d expected 3", bus.remainder); end
  endtask

  task automatic test_reset_mid;
    int done_cnt;
    int cyc;
    done_cnt = 0;
    start_op(16'd1000, 8'd7);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_checks++; if (bus.quotient !== 16'd0) begin n_fail++; $display("[TB] FAIL rstmid_quotient: got %0d expected 0", bus.quotient); end
    n_checks++; if (bus.remainder !== 8'd0) begin n_fail++; $display("[TB] FAIL rstmid_remainder: got %0d expected 0", bus.remainder); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_done: got %b expected 0", bus.done); end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.done) done_cnt++;
    end
    n_checks++; if (done_cnt !== 0) begin n_fail++; $display("[TB] FAIL rstmid_no_done: got %0d expected 0", done_cnt); end
    start_op(16'd1000, 8'd7);
    wait_done(cyc);
    n_checks++; if (cyc !== 16) begin n_fail++; $display("[TB] FAIL rstmid_restart_latency: got %0d expected 16", cyc); end
    n_checks++; if (bus.quotient !== 16'd142) begin n_fail++; $display("[TB] FAIL rstmid_restart_quotient: got %0d expected 142", bus.quotient); end
    n_checks++; if (bus.remainder !== 8'd6) begin n_fail++; $display("[TB] FAIL rstmid_restart_remainder: got %0d expected 6", bus.remainder); end
    @(posedge clk); #1;
  endtask

  // Each op is accepted the edge after the previous done, so completions land at 17, 34, 51, 68.
  task automatic test_back_to_back;
    int done_cnt;
    int first_edge;
    int cyc;
    done_cnt = 0; first_edge = -1;
    bus.dividend = 16'd1000; bus.divisor = 8'd7; bus.start = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        done_cnt++;
        if (first_edge < 0) first_edge = i;
        n_checks++; if (i % 17 != 0) begin n_fail++; $display("[TB] FAIL b2b_done_edge: got %0d expected multiple of 17", i); end
        n_checks++; if (bus.quotient !== 16'd142 || bus.remainder !== 8'd6) begin n_fail++; $display("[TB] FAIL b2b_result: got %0d r%0d expected 142 r6", bus.quotient, bus.remainder); end
      end
    end
    bus.start = 1'b0;
    n_checks++; if (first_edge !== 17) begin n_fail++; $display("[TB] FAIL b2b_first_done: got %0d expected 17", first_edge); end
    n_checks++; if (done_cnt !== 3) begin n_fail++; $display("[TB] FAIL b2b_done_count: got %0d expected 3", done_cnt); end
    wait_done(cyc);
    n_checks++; if (cyc !== 8) begin n_fail++; $display("[TB] FAIL b2b_drain_latency: got %0d expected 8", cyc); end
    n_checks++; if (bus.quotient !== 16'd142) begin n_fail++; $display("[TB] FAIL b2b_drain_quotient: got %0d expected 142", bus.quotient); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_limits();
    test_div_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
